// File: rtl/croc_pad_mux.sv
// Pad-function multiplexer: routes each bidirectional pad to one of NumFuncs peripheral
// functions, with per-pad config registers, input synchronisers and glitch filters.
module croc_pad_mux #(
   parameter int unsigned NumPads      = 32,
   parameter int unsigned NumFuncs     = 4,
   parameter int unsigned FilterCycles = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         cfg_req_i,
   input  logic                         cfg_we_i,
   input  logic [5:0]                   cfg_addr_i,
   input  logic [31:0]                  cfg_wdata_i,
   output logic                         cfg_rvalid_o,
   output logic [31:0]                  cfg_rdata_o,
   output logic                         cfg_err_o,
   input  logic [NumPads-1:0]           pad_in_i,
   output logic [NumPads-1:0]           pad_out_o,
   output logic [NumPads-1:0]           pad_oe_o,
   input  logic [NumFuncs*NumPads-1:0]  func_out_i,
   input  logic [NumFuncs*NumPads-1:0]  func_oe_i,
   output logic [NumFuncs*NumPads-1:0]  func_in_o
);

   localparam int unsigned AddrW = 6;
   localparam int unsigned DataW = 32;
   localparam int unsigned CntW  = 4;

   logic [NumPads-1:0][1:0]      r_sel;
   logic [NumPads-1:0]           r_filt_en;
   logic [NumPads-1:0]           r_force;
   logic [NumPads-1:0]           r_sync1;
   logic [NumPads-1:0]           r_sync2;
   logic [NumPads-1:0]           r_filt;
   logic [NumPads-1:0][CntW-1:0] r_cnt;
   logic                         r_rvalid;
   logic [DataW-1:0]             r_rdata;
   logic                         r_err;

   logic                         w_addr_ok;
   logic                         w_sel_ok;
   logic                         w_wr_ok;
   logic [NumPads-1:0]           w_wr_hit;
   logic [DataW-1:0]             w_rd_word;
   logic                         w_unused;

   assign w_addr_ok = 32'(cfg_addr_i) < NumPads;
   assign w_sel_ok  = 32'(cfg_wdata_i[1:0]) < NumFuncs;
   assign w_wr_ok   = cfg_req_i & cfg_we_i & w_addr_ok & w_sel_ok;
   assign w_unused  = ^{cfg_wdata_i[31:9], cfg_wdata_i[7:5], cfg_wdata_i[3:2]};

   // Address decode and read-data mux; out-of-range addresses fall through to zero
   always_comb begin
      w_wr_hit  = '0;
      w_rd_word = '0;
      for (int p = 0; p < int'(NumPads); p++) begin
         if (cfg_addr_i == AddrW'(p)) begin
            w_wr_hit[p] = w_wr_ok;
            w_rd_word   = {23'd0, r_force[p], 3'd0, r_filt_en[p], 2'd0, r_sel[p]};
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sel     <= '0;
         r_filt_en <= '0;
         r_force   <= '0;
      end else begin
         for (int p = 0; p < int'(NumPads); p++) begin
            if (w_wr_hit[p]) begin
               r_sel[p]     <= cfg_wdata_i[1:0];
               r_filt_en[p] <= cfg_wdata_i[4];
               r_force[p]   <= cfg_wdata_i[8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= cfg_req_i;
         r_rdata  <= (cfg_req_i && !cfg_we_i) ? w_rd_word : '0;
         r_err    <= cfg_req_i & (~w_addr_ok | (cfg_we_i & ~w_sel_ok));
      end
   end

   assign cfg_rvalid_o = r_rvalid;
   assign cfg_rdata_o  = r_rdata;
   assign cfg_err_o    = r_err;

   // Synchroniser plus stability filter; a config write restarts the stability count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_filt  <= '0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= pad_in_i;
         r_sync2 <= r_sync1;
         for (int p = 0; p < int'(NumPads); p++) begin
            if (w_wr_hit[p]) begin
               r_cnt[p] <= '0;
            end else if (!r_filt_en[p]) begin
               r_filt[p] <= r_sync2[p];
               r_cnt[p]  <= '0;
            end else if (r_sync2[p] == r_filt[p]) begin
               r_cnt[p] <= '0;
            end else if (r_cnt[p] == CntW'(FilterCycles - 1)) begin
               r_filt[p] <= r_sync2[p];
               r_cnt[p]  <= '0;
            end else begin
               r_cnt[p] <= r_cnt[p] + CntW'(1);
            end
         end
      end
   end

   // Function routing; unselected function inputs idle high
   always_comb begin
      pad_out_o = '0;
      pad_oe_o  = '0;
      func_in_o = '1;
      for (int f = 0; f < int'(NumFuncs); f++) begin
         for (int p = 0; p < int'(NumPads); p++) begin
            if (r_sel[p] == 2'(f)) begin
               pad_out_o[p]                = func_out_i[f*int'(NumPads)+p];
               pad_oe_o[p]                 = func_oe_i[f*int'(NumPads)+p] & ~r_force[p];
               func_in_o[f*int'(NumPads)+p] = r_filt[p];
            end
         end
      end
   end

endmodule

// File: tb/tb_croc_pad_mux.sv
// Scoreboard bench for croc_pad_mux: config responses checked by a monitor against a
// queue of expected values; pad paths checked directly at fixed latencies.
module tb_croc_pad_mux;

   localparam int unsigned NP = 32;
   localparam int unsigned NF = 3;
   localparam int unsigned FC = 4;
   localparam int unsigned FW = NP * NF;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           cfg_req_i = 1'b0;
   logic           cfg_we_i = 1'b0;
   logic [5:0]     cfg_addr_i = '0;
   logic [31:0]    cfg_wdata_i = '0;
   logic           cfg_rvalid_o;
   logic [31:0]    cfg_rdata_o;
   logic           cfg_err_o;
   logic [NP-1:0]  pad_in_i = '0;
   logic [NP-1:0]  pad_out_o;
   logic [NP-1:0]  pad_oe_o;
   logic [FW-1:0]  func_out_i = '0;
   logic [FW-1:0]  func_oe_i = '0;
   logic [FW-1:0]  func_in_o;

   int total = 0;
   int bad   = 0;
   logic [32:0] exp_q[$];

   croc_pad_mux #(.NumPads(NP), .NumFuncs(NF), .FilterCycles(FC)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
      .cfg_wdata_i(cfg_wdata_i), .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o),
      .cfg_err_o(cfg_err_o), .pad_in_i(pad_in_i), .pad_out_o(pad_out_o),
      .pad_oe_o(pad_oe_o), .func_out_i(func_out_i), .func_oe_i(func_oe_i),
      .func_in_o(func_in_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // One config request; expected {err, rdata} goes to the scoreboard
   task automatic cfg(input logic we, input logic [5:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
      cfg_req_i   = 1'b1;
      cfg_we_i    = we;
      cfg_addr_i  = addr;
      cfg_wdata_i = wd;
      exp_q.push_back({exp_err, exp_rd});
      tick(1);
      cfg_req_i = 1'b0;
   endtask

   // Response monitor
   always @(negedge clk_i) begin
      if (!rst_i && cfg_rvalid_o) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL cfg_unexpected act=%h exp=none", {cfg_err_o, cfg_rdata_o});
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            chk("cfg_resp", FW'({cfg_err_o, cfg_rdata_o}), FW'(e));
         end
      end
   end

   initial begin
      logic [FW-1:0] idle;
      idle = {{(FW-NP){1'b1}}, {NP{1'b0}}};

      tick(3);
      chk("reset_func_in", func_in_o, idle);
      chk("reset_rvalid", FW'(cfg_rvalid_o), FW'(0));
      rst_i = 1'b0;
      tick(1);

      // GPIO default routing
      cfg(1'b0, 6'd5, 32'h0, 32'h0, 1'b0);
      func_oe_i[5]  = 1'b1;
      func_out_i[5] = 1'b1;
      #1;
      chk("gpio_oe5", FW'(pad_oe_o[5]), FW'(1));
      chk("gpio_out5", FW'(pad_out_o[5]), FW'(1));

      // Function 2 on pad 3
      func_out_i[2*NP+3] = 1'b0;
      func_oe_i[2*NP+3]  = 1'b1;
      func_out_i[3]      = 1'b1;
      func_oe_i[3]       = 1'b0;
      cfg(1'b1, 6'd3, 32'h2, 32'h0, 1'b0);
      chk("f2_out3", FW'(pad_out_o[3]), FW'(0));
      chk("f2_oe3", FW'(pad_oe_o[3]), FW'(1));
      pad_in_i[3] = 1'b1;
      tick(2);
      chk("f2_in_lat2", FW'(func_in_o[2*NP+3]), FW'(0));
      tick(1);
      chk("f2_in_lat3", FW'(func_in_o[2*NP+3]), FW'(1));
      chk("gpio_in3_idle", FW'(func_in_o[3]), FW'(1));
      chk("f1_in3_idle", FW'(func_in_o[NP+3]), FW'(1));

      // force_in suppresses output enable
      cfg(1'b1, 6'd3, 32'h102, 32'h0, 1'b0);
      chk("force_oe3", FW'(pad_oe_o[3]), FW'(0));
      cfg(1'b0, 6'd3, 32'h0, 32'h102, 1'b0);

      // Glitch filter on pad 7
      cfg(1'b1, 6'd7, 32'h10, 32'h0, 1'b0);
      pad_in_i[7] = 1'b1;
      tick(3);
      pad_in_i[7] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         chk("filt_pulse", FW'(func_in_o[7]), FW'(0));
      end
      pad_in_i[7] = 1'b1;
      tick(5);
      chk("filt_edge5", FW'(func_in_o[7]), FW'(0));
      tick(1);
      chk("filt_edge6", FW'(func_in_o[7]), FW'(1));

      // Error cases
      cfg(1'b1, 6'd7, 32'h3, 32'h0, 1'b1);
      cfg(1'b0, 6'd7, 32'h0, 32'h10, 1'b0);
      cfg(1'b0, 6'd40, 32'h0, 32'h0, 1'b1);
      cfg(1'b1, 6'd40, 32'h1, 32'h0, 1'b1);

      // Back-to-back write then read
      func_out_i[NP+1] = 1'b1;
      cfg(1'b1, 6'd1, 32'h1, 32'h0, 1'b0);
      cfg(1'b0, 6'd1, 32'h0, 32'h1, 1'b0);
      chk("f1_out1", FW'(pad_out_o[1]), FW'(1));
      tick(2);

      // Reset mid-stream with a request pending
      cfg_req_i  = 1'b1;
      cfg_we_i   = 1'b0;
      cfg_addr_i = 6'd3;
      rst_i      = 1'b1;
      tick(2);
      chk("rst_rvalid", FW'(cfg_rvalid_o), FW'(0));
      chk("rst_func_in", func_in_o, idle);
      cfg_req_i = 1'b0;
      rst_i     = 1'b0;
      tick(1);
      chk("post_rst_rvalid", FW'(cfg_rvalid_o), FW'(0));
      cfg(1'b0, 6'd1, 32'h0, 32'h0, 1'b0);
      cfg(1'b0, 6'd3, 32'h0, 32'h0, 1'b0);
      cfg(1'b0, 6'd7, 32'h0, 32'h0, 1'b0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick(1);
      chk("scoreboard_drained", FW'(exp_q.size()), FW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
